// File: rtl/tx_serializer_if.sv
// Handshake and serial-line bundle between a symbol source and tx_serializer.
interface tx_serializer_if #(
  parameter int DATA_WIDTH = 10
);
  logic                  tx_en;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  Dout;
  logic                  sym_start;
  logic                  idle_ins;

  modport master (
    output tx_en, tx_data, tx_valid,
    input  tx_ready, Dout, sym_start, idle_ins
  );

  modport slave (
    input  tx_en, tx_data, tx_valid,
    output tx_ready, Dout, sym_start, idle_ins
  );
endinterface

// File: rtl/tx_serializer.sv
// Transmit-side parallel-to-serial converter: a one-entry holding buffer feeds
// a shift register that streams one bit per clock with no gaps between
// symbols, substituting an idle/comma symbol whenever the buffer is empty.
module tx_serializer #(
  parameter int                    DATA_WIDTH   = 10,
  parameter bit                    LSB_FIRST    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] IDLE_PATTERN = 10'h17C
) (
  input logic            clk,
  input logic            rst,
  tx_serializer_if.slave bus
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  localparam logic [0:0] ST_OFF = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;

  logic [0:0]            r_state;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [CW-1:0]         r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_buf_data;
  logic                  r_buf_valid;
  logic                  r_sym_start;
  logic                  r_idle_ins;

  logic                  w_load;
  logic                  w_xfer;
  logic                  w_last_bit;
  logic [DATA_WIDTH-1:0] w_shifted;

  // Symbol boundary: enable while off, or enable on the last bit of a symbol.
  always_comb begin
    w_last_bit = (r_state == ST_RUN) && (r_bit_cnt == LAST_BIT);
    w_load     = bus.tx_en && ((r_state == ST_OFF) || w_last_bit);
  end

  // Ready depends only on buffer occupancy and the boundary, never on tx_valid.
  assign bus.tx_ready = !rst && (!r_buf_valid || w_load);
  assign w_xfer       = bus.tx_valid && bus.tx_ready;

  // Zero-filled shift toward the output end, so the register empties to all
  // zeros by the time a symbol has fully gone out and the line idles low.
  always_comb begin
    if (LSB_FIRST) begin
      w_shifted = {1'b0, r_shreg[DATA_WIDTH-1:1]};
    end else begin
      w_shifted = {r_shreg[DATA_WIDTH-2:0], 1'b0};
    end
  end

  // The line bit comes straight from the shift register, so Dout is registered.
  assign bus.Dout      = LSB_FIRST ? r_shreg[0] : r_shreg[DATA_WIDTH-1];
  assign bus.sym_start = r_sym_start;
  assign bus.idle_ins  = r_idle_ins;

  // Holding buffer: drains at every boundary, a simultaneous transfer refills it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf_valid <= 1'b0;
      r_buf_data  <= '0;
    end else if (w_load) begin
      r_buf_valid <= w_xfer;
      if (w_xfer) begin
        r_buf_data <= bus.tx_data;
      end
    end else if (w_xfer) begin
      r_buf_valid <= 1'b1;
      r_buf_data  <= bus.tx_data;
    end
  end

  // Line state, shift register and bit counter; a symbol always completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_OFF;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
    end else if (w_load) begin
      r_state   <= ST_RUN;
      r_shreg   <= r_buf_valid ? r_buf_data : IDLE_PATTERN;
      r_bit_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_shreg <= w_shifted;
      if (w_last_bit) begin
        r_state   <= ST_OFF;
        r_bit_cnt <= '0;
      end else begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  // Symbol markers: start pulse on the first bit, idle flag held per symbol.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sym_start <= 1'b0;
      r_idle_ins  <= 1'b0;
    end else begin
      r_sym_start <= w_load;
      if (w_load) begin
        r_idle_ins <= !r_buf_valid;
      end else if (w_last_bit) begin
        r_idle_ins <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tx_serializer.sv
// Self-checking bench for tx_serializer: an LSB-first and an MSB-first
// instance share stimulus and are compared every cycle against a
// symbol-level reference model of the line.
module tb_tx_serializer;

  localparam int DW = 10;
  localparam logic [DW-1:0] IDLE = 10'h17C;

  logic clk = 1'b0;
  logic rst;

  int vectorCount = 0;
  int missCount   = 0;

  // Reference model: the symbol on the line and which of its bits is showing.
  bit            mRun;
  int            mIdx;
  logic [DW-1:0] mSym;
  bit            mBufFull;
  logic [DW-1:0] mBufData;
  bit            mSymStart;
  bit            mIdle;
  bit            mLastReady;
  bit            mLastXfer;

  logic lastDoutLsb;
  logic lastDoutMsb;

  tx_serializer_if #(.DATA_WIDTH(DW)) ifLsb ();
  tx_serializer_if #(.DATA_WIDTH(DW)) ifMsb ();

  tx_serializer #(.DATA_WIDTH(DW), .LSB_FIRST(1'b1), .IDLE_PATTERN(IDLE)) dutLsb (
    .clk (clk),
    .rst (rst),
    .bus (ifLsb.slave)
  );

  tx_serializer #(.DATA_WIDTH(DW), .LSB_FIRST(1'b0), .IDLE_PATTERN(IDLE)) dutMsb (
    .clk (clk),
    .rst (rst),
    .bus (ifMsb.slave)
  );

  // Free-running bit clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic en, input logic v,
                               input logic [DW-1:0] d);
    rst            = r;
    ifLsb.tx_en    = en;
    ifMsb.tx_en    = en;
    ifLsb.tx_valid = v;
    ifMsb.tx_valid = v;
    ifLsb.tx_data  = d;
    ifMsb.tx_data  = d;
  endtask

  function automatic bit modelBoundary();
    return ifLsb.tx_en && (!mRun || mIdx == DW - 1);
  endfunction

  function automatic bit modelReady();
    return !rst && (!mBufFull || modelBoundary());
  endfunction

  task automatic modelClear();
    mRun = 0; mIdx = 0; mSym = '0; mBufFull = 0; mBufData = '0;
    mSymStart = 0; mIdle = 0; mLastReady = 0; mLastXfer = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic modelUpdate();
    bit boundary;
    bit ready;
    bit xfer;
    boundary   = modelBoundary();
    ready      = modelReady();
    xfer       = ifLsb.tx_valid && ready;
    mLastReady = ready;
    mLastXfer  = xfer;
    if (rst) begin
      modelClear();
    end else if (boundary) begin
      mSym      = mBufFull ? mBufData : IDLE;
      mIdle     = !mBufFull;
      mRun      = 1;
      mIdx      = 0;
      mSymStart = 1;
      mBufFull  = xfer;
      if (xfer) mBufData = ifLsb.tx_data;
    end else begin
      mSymStart = 0;
      if (mRun) begin
        if (mIdx == DW - 1) begin
          mRun  = 0;
          mIdx  = 0;
          mIdle = 0;
        end else begin
          mIdx++;
        end
      end
      if (xfer) begin
        mBufFull = 1;
        mBufData = ifLsb.tx_data;
      end
    end
  endtask

  // One clock: compare both instances mid-cycle, then step the model at the edge.
  task automatic stepCycle();
    logic expLsb;
    logic expMsb;
    @(negedge clk);
    expLsb = mRun ? mSym[mIdx] : 1'b0;
    expMsb = mRun ? mSym[DW - 1 - mIdx] : 1'b0;
    checkOutput("doutLsb", 32'(ifLsb.Dout), 32'(expLsb));
    checkOutput("doutMsb", 32'(ifMsb.Dout), 32'(expMsb));
    checkOutput("symStartLsb", 32'(ifLsb.sym_start), 32'(mSymStart));
    checkOutput("symStartMsb", 32'(ifMsb.sym_start), 32'(mSymStart));
    checkOutput("idleInsLsb", 32'(ifLsb.idle_ins), 32'(mIdle));
    checkOutput("idleInsMsb", 32'(ifMsb.idle_ins), 32'(mIdle));
    checkOutput("txReadyLsb", 32'(ifLsb.tx_ready), 32'(modelReady()));
    checkOutput("txReadyMsb", 32'(ifMsb.tx_ready), 32'(modelReady()));
    lastDoutLsb = ifLsb.Dout;
    lastDoutMsb = ifMsb.Dout;
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic waitUntilAccepted(input string tag);
    int n = 0;
    do begin
      stepCycle();
      n++;
    end while (!mLastXfer && n < 40);
    if (!mLastXfer) checkOutput(tag, 32'd0, 32'd1);
  endtask

  task automatic waitForSymbol(input string tag, input logic [DW-1:0] sym);
    int n = 0;
    while (!(mSymStart && mSym == sym) && n < 60) begin
      stepCycle();
      n++;
    end
    if (!(mSymStart && mSym == sym)) checkOutput(tag, 32'd0, 32'd1);
  endtask

  task automatic waitForBit(input string tag, input int idx);
    int n = 0;
    while (mIdx != idx && n < 20) begin
      stepCycle();
      n++;
    end
    if (mIdx != idx) checkOutput(tag, 32'd0, 32'd1);
  endtask

  // Collect n line bits; the first bit sent lands in bit 0 of the word.
  task automatic captureWord(input int n, output logic [31:0] wLsb,
                             output logic [31:0] wMsb);
    wLsb = '0;
    wMsb = '0;
    for (int i = 0; i < n; i++) begin
      stepCycle();
      wLsb[i] = lastDoutLsb;
      wMsb[i] = lastDoutMsb;
    end
  endtask

  initial begin
    logic [31:0] wLsb;
    logic [31:0] wMsb;
    logic        curEn;
    logic        curValid;
    logic [DW-1:0] curData;

    // Reset held with enable and valid asserted.
    applyStimulus(1'b1, 1'b1, 1'b1, 10'h155);
    @(posedge clk);
    #1;
    modelClear();
    runCycles(3);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    runCycles(2);

    // Single symbol, then idle fill.
    applyStimulus(1'b0, 1'b0, 1'b1, 10'h2AA);
    waitUntilAccepted("accept2AA");
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    runCycles(2);
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    stepCycle();
    captureWord(DW, wLsb, wMsb);
    checkOutput("single2AA_lsbWord", wLsb, 32'h2AA);
    checkOutput("single2AA_msbWord", wMsb, 32'h155);
    runCycles(12);

    // Back-to-back all-ones then all-zeros.
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h3FF);
    waitUntilAccepted("accept3FF");
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h000);
    waitUntilAccepted("accept000");
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    waitForSymbol("start3FF", 10'h3FF);
    captureWord(2 * DW, wLsb, wMsb);
    checkOutput("backToBackWord", wLsb, 32'h003FF);

    // Underrun: idle symbols only.
    runCycles(25);

    // Enable dropped at bit 3; a symbol buffered while off goes out first later.
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h2AA);
    waitUntilAccepted("accept2AAdrop");
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    waitForSymbol("start2AAdrop", 10'h2AA);
    waitForBit("reachBit3", 3);
    applyStimulus(1'b0, 1'b0, 1'b1, 10'h155);
    waitUntilAccepted("accept155");
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    runCycles(15);
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    stepCycle();
    captureWord(DW, wLsb, wMsb);
    checkOutput("pendingFirstWord", wLsb, 32'h155);

    // Mid-symbol reset discards the buffered symbol.
    waitForSymbol("idleBeforeReset", IDLE);
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h3C3);
    waitUntilAccepted("accept3C3");
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    waitForSymbol("start3C3", 10'h3C3);
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h0F0);
    stepCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    waitForBit("reachBit5", 5);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    runCycles(4);
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    stepCycle();
    captureWord(DW, wLsb, wMsb);
    checkOutput("afterResetIdleWord", wLsb, 32'h17C);

    // Comma symbol on both bit orders; MSB-first line reads 0,1,0,1,1,1,1,1,0,0.
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    runCycles(12);
    applyStimulus(1'b0, 1'b0, 1'b1, 10'h17C);
    waitUntilAccepted("accept17C");
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    stepCycle();
    captureWord(DW, wLsb, wMsb);
    checkOutput("single17C_lsbWord", wLsb, 32'h17C);
    checkOutput("single17C_msbWord", wMsb, 32'h0FA);

    // Randomized traffic with occasional enable toggles and resets.
    curEn    = 1'b1;
    curValid = 1'b0;
    curData  = '0;
    for (int i = 0; i < 600; i++) begin
      logic rstV;
      if ($urandom_range(0, 19) == 0) curEn = ~curEn;
      rstV = ($urandom_range(0, 149) == 0);
      if (!(curValid && !mLastReady)) begin
        curValid = ($urandom_range(0, 2) != 0);
        curData  = DW'($urandom);
      end
      applyStimulus(rstV, curEn, curValid, curData);
      stepCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
